// File: rtl/spike_rr_scheduler.sv
// spike_rr_scheduler: N-way round-robin arbiter that shares one registered spike-packet channel.
// Define ARB_GRANT_CNT_EN to add saturating per-requester packet-grant counters on grant_cnt.
module spike_rr_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PKT_LEN = 1,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned SRC_W  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SRC_W-1:0]   out_src,
  output logic               out_last,
  input  logic               out_ready
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [N*CNT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, stateNext;
  logic [BEAT_W-1:0] beatCnt, beatCntNext;
  logic [SRC_W-1:0]  rrPtr, rrPtrNext;
  logic [SRC_W-1:0]  scanIdx, rrIdx, srcIdx;
  logic              rrFound, grantOk, loadEn, xfer, firstBeat;
  logic [N-1:0]      sel;
  logic [WIDTH-1:0]  beatData [N];
  logic              outValidNext, outLastNext;
  logic [WIDTH-1:0]  outDataNext;
  logic [SRC_W-1:0]  outSrcNext;

  if (N < 2 || PKT_LEN == 0 || CNT_W == 0) begin : gBadParam
    $error("spike_rr_scheduler: N must be >= 2, PKT_LEN and CNT_W must be nonzero");
  end

  for (genvar i = 0; i < N; i++) begin : gUnpack
    assign beatData[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Round-robin scan starting just after the most recent packet winner
  always_comb begin
    rrFound = 1'b0;
    rrIdx   = rrPtr;
    scanIdx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      scanIdx = SRC_W'((32'(rrPtr) + k) % N);
      if (!rrFound && in_valid[scanIdx]) begin
        rrFound = 1'b1;
        rrIdx   = scanIdx;
      end
    end
  end

  // While locked, rrPtr already names the packet owner
  assign loadEn    = !out_valid || out_ready;
  assign srcIdx    = (state == LOCKED) ? rrPtr : rrIdx;
  assign grantOk   = (state == LOCKED) || rrFound;
  assign sel       = grantOk ? (N'(1) << srcIdx) : '0;
  assign in_ready  = loadEn ? sel : '0;
  assign xfer      = |(in_ready & in_valid);
  assign firstBeat = xfer && (state == IDLE);

  always_comb begin
    stateNext    = state;
    beatCntNext  = beatCnt;
    rrPtrNext    = rrPtr;
    outValidNext = out_valid;
    outDataNext  = out_data;
    outSrcNext   = out_src;
    outLastNext  = out_last;
    if (loadEn) begin
      outValidNext = xfer;
      if (xfer) begin
        outDataNext = beatData[srcIdx];
        outSrcNext  = srcIdx;
        unique case (state)
          IDLE: begin
            rrPtrNext = srcIdx;
            if (PKT_LEN == 1) begin
              outLastNext = 1'b1;
            end else begin
              outLastNext = 1'b0;
              beatCntNext = BEAT_W'(1);
              stateNext   = LOCKED;
            end
          end
          LOCKED: begin
            if (beatCnt == BEAT_W'(PKT_LEN - 1)) begin
              outLastNext = 1'b1;
              beatCntNext = '0;
              stateNext   = IDLE;
            end else begin
              outLastNext = 1'b0;
              beatCntNext = beatCnt + BEAT_W'(1);
            end
          end
          default: stateNext = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beatCnt   <= '0;
      rrPtr     <= SRC_W'(N - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= stateNext;
      beatCnt   <= beatCntNext;
      rrPtr     <= rrPtrNext;
      out_valid <= outValidNext;
      out_data  <= outDataNext;
      out_src   <= outSrcNext;
      out_last  <= outLastNext;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] grantCnt [N];

  // Packet-grant counters saturate rather than wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) grantCnt[i] <= '0;
    end else if (firstBeat && (grantCnt[srcIdx] != '1)) begin
      grantCnt[srcIdx] <= grantCnt[srcIdx] + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : gGrantOut
    assign grant_cnt[i*CNT_W +: CNT_W] = grantCnt[i];
  end
`endif

endmodule

// File: tb/tb_spike_rr_scheduler.sv
// Bench for spike_rr_scheduler: two instances (PKT_LEN=1 and PKT_LEN=3) driven with random
// valid/ready traffic, checked by a queue scoreboard against a packet-level reference model.
module tb_spike_rr_scheduler;
  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SRC_W = 2;
  localparam int          NDUT  = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SRC_W-1:0] src;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [N-1:0]       inValid  [NDUT];
  logic [N*WIDTH-1:0] inData   [NDUT];
  logic [N-1:0]       inReady  [NDUT];
  logic               outValid [NDUT];
  logic [WIDTH-1:0]   outData  [NDUT];
  logic [SRC_W-1:0]   outSrc   [NDUT];
  logic               outLast  [NDUT];
  logic               outReady [NDUT];
`ifdef ARB_GRANT_CNT_EN
  logic [N*CNT_W-1:0] grantCnt [NDUT];
`endif

  spike_rr_scheduler #(.N(N), .WIDTH(WIDTH), .PKT_LEN(1), .CNT_W(CNT_W)) dutA (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_data(inData[0]), .in_ready(inReady[0]),
    .out_valid(outValid[0]), .out_data(outData[0]), .out_src(outSrc[0]),
    .out_last(outLast[0]), .out_ready(outReady[0])
`ifdef ARB_GRANT_CNT_EN
    , .grant_cnt(grantCnt[0])
`endif
  );

  spike_rr_scheduler #(.N(N), .WIDTH(WIDTH), .PKT_LEN(3), .CNT_W(CNT_W)) dutB (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_data(inData[1]), .in_ready(inReady[1]),
    .out_valid(outValid[1]), .out_data(outData[1]), .out_src(outSrc[1]),
    .out_last(outLast[1]), .out_ready(outReady[1])
`ifdef ARB_GRANT_CNT_EN
    , .grant_cnt(grantCnt[1])
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state (packet level)
  int   lastWin [NDUT];
  int   owner   [NDUT];
  int   sent    [NDUT];
  bit   occ     [NDUT];
  int   grants  [NDUT][N];
  bit   pending [NDUT][N];
  bit   accepted[NDUT][N];
  logic [WIDTH-1:0] reqData [NDUT][N];
  int   pValid;
  int   pReady;

  beat_t sbq0[$];
  beat_t sbq1[$];
  logic [SRC_W-1:0] log0[$];
  logic [SRC_W-1:0] log1[$];

  function automatic int pktLen(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void sbPush(int k, beat_t b);
    if (k == 0) sbq0.push_back(b); else sbq1.push_back(b);
  endfunction

  function automatic int sbSize(int k);
    return (k == 0) ? sbq0.size() : sbq1.size();
  endfunction

  function automatic beat_t sbPop(int k);
    return (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
  endfunction

  function automatic void resetModel(int k);
    lastWin[k] = N - 1;
    owner[k]   = -1;
    sent[k]    = 0;
    occ[k]     = 1'b0;
    for (int i = 0; i < N; i++) begin
      grants[k][i]   = 0;
      pending[k][i]  = 1'b0;
      accepted[k][i] = 1'b0;
      reqData[k][i]  = '0;
    end
    inValid[k] = '0;
    inData[k]  = '0;
    if (k == 0) begin sbq0.delete(); log0.delete(); end
    else        begin sbq1.delete(); log1.delete(); end
  endfunction

  // requesters hold valid/data until accepted, then may start a new beat at random
  function automatic void drive(int k);
    for (int i = 0; i < N; i++) begin
      if (accepted[k][i]) pending[k][i] = 1'b0;
      accepted[k][i] = 1'b0;
      if (!pending[k][i] && ($urandom_range(99) < pValid)) begin
        pending[k][i] = 1'b1;
        reqData[k][i] = WIDTH'($urandom);
      end
      inValid[k][i] = pending[k][i];
      inData[k][i*WIDTH +: WIDTH] = reqData[k][i];
    end
    outReady[k] = ($urandom_range(99) < pReady);
  endfunction

  // predict in_ready and the beat accepted at the coming edge
  function automatic void modelStep(int k);
    bit loadEn;
    int cand;
    logic [N-1:0] expReady;
    beat_t b;
    loadEn   = !occ[k] || outReady[k];
    cand     = -1;
    expReady = '0;
    if (owner[k] >= 0) cand = owner[k];
    else begin
      for (int j = 1; j <= N; j++) begin
        int r;
        r = (lastWin[k] + j) % N;
        if (cand < 0 && inValid[k][r]) cand = r;
      end
    end
    if (loadEn && cand >= 0) expReady[cand] = 1'b1;
    check($sformatf("in_ready dut%0d", k), 64'(inReady[k]), 64'(expReady));
    if (loadEn) begin
      if (cand >= 0 && inValid[k][cand]) begin
        accepted[k][cand] = 1'b1;
        if (owner[k] < 0) begin
          lastWin[k] = cand;
          grants[k][cand]++;
          sent[k] = 1;
        end else begin
          sent[k]++;
        end
        b.data = reqData[k][cand];
        b.src  = SRC_W'(cand);
        b.last = (sent[k] == pktLen(k));
        owner[k] = b.last ? -1 : cand;
        sbPush(k, b);
        occ[k] = 1'b1;
      end else begin
        occ[k] = 1'b0;
      end
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) drive(k);
    #1;
    for (int k = 0; k < NDUT; k++) modelStep(k);
  endtask

  function automatic void checkResetOutputs(string tag);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s out_valid dut%0d", tag, k), 64'(outValid[k]), 64'(0));
      check($sformatf("%s out_data dut%0d", tag, k), 64'(outData[k]), 64'(0));
      check($sformatf("%s out_src dut%0d", tag, k), 64'(outSrc[k]), 64'(0));
      check($sformatf("%s out_last dut%0d", tag, k), 64'(outLast[k]), 64'(0));
`ifdef ARB_GRANT_CNT_EN
      check($sformatf("%s grant_cnt dut%0d", tag, k), 64'(grantCnt[k]), 64'(0));
`endif
    end
  endfunction

  task automatic midReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    for (int k = 0; k < NDUT; k++) resetModel(k);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: pop the scoreboard on every output handshake
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        for (int k = 0; k < NDUT; k++) begin
          if (outValid[k] && outReady[k]) begin
            if (sbSize(k) == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected beat dut%0d: got src %0d data %0h, expected none (t=%0t)",
                       k, outSrc[k], outData[k], $time);
            end else begin
              e = sbPop(k);
              check($sformatf("out_data dut%0d", k), 64'(outData[k]), 64'(e.data));
              check($sformatf("out_src dut%0d", k), 64'(outSrc[k]), 64'(e.src));
              check($sformatf("out_last dut%0d", k), 64'(outLast[k]), 64'(e.last));
            end
            if (k == 0) log0.push_back(outSrc[k]); else log1.push_back(outSrc[k]);
          end
        end
      end
    end
  end

  initial begin
    bit resetDone;
    resetDone = 1'b0;
    pValid = 0;
    pReady = 100;
    for (int k = 0; k < NDUT; k++) begin
      resetModel(k);
      outReady[k] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // all requesters valid, no back-pressure: strict rotation from requester 0
    pValid = 100;
    pReady = 100;
    repeat (5) cycle();
`ifdef ARB_GRANT_CNT_EN
    @(posedge clk);
    #1;
    check("grant_cnt[0] after 5 beats", 64'(grantCnt[0][0*CNT_W +: CNT_W]), 64'(2));
    check("grant_cnt[1] after 5 beats", 64'(grantCnt[0][1*CNT_W +: CNT_W]), 64'(1));
    check("grant_cnt[2] after 5 beats", 64'(grantCnt[0][2*CNT_W +: CNT_W]), 64'(1));
    check("grant_cnt[3] after 5 beats", 64'(grantCnt[0][3*CNT_W +: CNT_W]), 64'(1));
`endif
    pValid = 0;
    repeat (6) cycle();
    check("rotation log length", 64'(log0.size() >= 5), 64'(1));
    if (log0.size() >= 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("rotation src #%0d", i), 64'(log0[i]), 64'(i % 4));

    // random traffic with a reset landing after the second beat of a 3-beat packet
    pValid = 50;
    pReady = 70;
    for (int c = 0; c < 1500; c++) begin
      if (!resetDone && c > 200 && owner[1] >= 0 && sent[1] == 2) begin
        midReset();
        resetDone = 1'b1;
        pValid = 100;
        pReady = 100;
        repeat (8) cycle();
        check("post-reset log length", 64'((log0.size() >= 1) && (log1.size() >= 4)), 64'(1));
        if (log0.size() >= 1) check("post-reset first src pkt1", 64'(log0[0]), 64'(0));
        if (log1.size() >= 4) begin
          check("post-reset beat0 src pkt3", 64'(log1[0]), 64'(0));
          check("post-reset beat1 src pkt3", 64'(log1[1]), 64'(0));
          check("post-reset beat2 src pkt3", 64'(log1[2]), 64'(0));
          check("post-reset next packet src pkt3", 64'(log1[3]), 64'(1));
        end
        pValid = 50;
        pReady = 70;
      end
      cycle();
    end
    if (!resetDone) midReset();

    // heavy back-pressure
    pValid = 70;
    pReady = 20;
    repeat (800) cycle();

    // drain
    pValid = 0;
    pReady = 100;
    repeat (20) cycle();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("scoreboard empty dut%0d", k), 64'(sbSize(k)), 64'(0));
`ifdef ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++)
        check($sformatf("grant_cnt dut%0d req%0d", k, i),
              64'(grantCnt[k][i*CNT_W +: CNT_W]), 64'(grants[k][i]));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
